seq_divider: RTL and testbench

Sequential restoring divider that performs the inverse of the ALU's multiply operation: an 8-bit dividend divided by a 4-bit divisor, producing an 8-bit quotient and a 4-bit remainder. It computes one quotient bit per clock and uses a start/busy/done handshake. It sits next to the ALU/register datapath. Operands come from the switches or the accumulator register, and the results drive the hex decoders and LEDs.

---
 rtl/seq_divider.sv | 115 +++++++++++
 tb/tb_seq_divider.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor,
// one quotient bit per clock, start/busy/done handshake, divide-by-zero flag.
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [DIVIDEND_W-1:0] q_reg, q_next;
    logic [DIVISOR_W:0]    r_reg, r_next;
    logic [DIVISOR_W-1:0]  dvs_reg, dvs_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DIVIDEND_W-1:0] quot_reg, quot_next;
    logic [DIVISOR_W-1:0]  rem_reg, rem_next;
    logic                  dbz_reg, dbz_next;

    // One restoring step: shift {R,Q} left, subtract the divisor if it fits.
    logic [DIVISOR_W+1:0]  shifted;
    logic                  fits;
    logic [DIVISOR_W:0]    r_step;
    logic [DIVIDEND_W-1:0] q_step;

    always_comb begin
        shifted = {r_reg, q_reg[DIVIDEND_W-1]};
        fits    = shifted >= (DIVISOR_W+2)'(dvs_reg);
        r_step  = fits ? (DIVISOR_W+1)'(shifted - (DIVISOR_W+2)'(dvs_reg))
                       : (DIVISOR_W+1)'(shifted);
        q_step  = {q_reg[DIVIDEND_W-2:0], fits};
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            r_reg     <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            dvs_reg   <= dvs_next;
            cnt_reg   <= cnt_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            dbz_reg   <= dbz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        dvs_next   = dvs_reg;
        cnt_next   = cnt_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        dbz_next   = dbz_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_next  = '1;
                        rem_next   = '0;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        q_next     = dividend;
                        r_next     = '0;
                        dvs_next   = divisor;
                        cnt_next   = '0;
                        dbz_next   = 1'b0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                q_next   = q_step;
                r_next   = r_step;
                cnt_next = cnt_reg + 1'b1;
                // The step taking the counter to DIVIDEND_W is the last one.
                if (cnt_reg == CNT_W'(DIVIDEND_W - 1)) begin
                    quot_next  = q_step;
                    rem_next   = r_step[DIVISOR_W-1:0];
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign div_by_zero = dbz_reg;
    assign quotient    = quot_reg;
    assign remainder   = rem_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: timeline model using plain / and %,
// per-cycle output comparison, directed corner cases, sweep and random traffic.
module tb_seq_divider;
    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient;
    logic [3:0] remainder;

    seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .CLK(CLK), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_cnt 0 = idle, 1..8 = dividing, 9 = result/done cycle.
    int         m_cnt = 0;
    int         acc_cnt = 0;
    logic [7:0] m_q = '0, m_pq = '0, m_dd = '0;
    logic [3:0] m_r = '0, m_pr = '0, m_dv = '0;
    logic       m_dbz = 1'b0;

    always @(posedge CLK) begin
        if (!reset) begin
            m_cnt <= 0;
            m_q   <= '0;
            m_r   <= '0;
            m_dbz <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                acc_cnt <= acc_cnt + 1;
                m_dd    <= dividend;
                m_dv    <= divisor;
                if (divisor == 4'd0) begin
                    m_q   <= 8'hFF;
                    m_r   <= 4'h0;
                    m_dbz <= 1'b1;
                    m_cnt <= 9;
                end else begin
                    m_pq  <= dividend / 8'(divisor);
                    m_pr  <= 4'(dividend % 8'(divisor));
                    m_dbz <= 1'b0;
                    m_cnt <= 1;
                end
            end
        end else if (m_cnt == 8) begin
            m_q   <= m_pq;
            m_r   <= m_pr;
            m_cnt <= 9;
        end else if (m_cnt == 9) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    logic chk_en = 1'b0;
    logic sweep_on = 1'b0;
    int   cyc = 0;
    int   last_done = -1;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (!sweep_on) last_done <= -1;
        if (chk_en) begin
            check("outputs", {17'b0, busy, done, div_by_zero, quotient, remainder},
                  {17'b0, (m_cnt >= 1 && m_cnt <= 8), (m_cnt == 9), m_dbz, m_q, m_r});
            if (done && !div_by_zero)
                check("invariant", {31'b0, ((32'(quotient) * 32'(m_dv) + 32'(remainder)) == 32'(m_dd))
                                          && (remainder < m_dv)}, 32'd1);
            if (done && sweep_on) begin
                if (last_done >= 0) check("done_period", cyc - last_done, 32'd10);
                last_done <= cyc;
            end
        end
    end

    task automatic run_op(input string name, input logic [7:0] dd, input logic [3:0] dv,
                          input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                          input int elat);
        int nbusy;
        int lat;
        @(negedge CLK);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        nbusy    = 0;
        lat      = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, lat, elat);
        check({name, "_busy_cycles"}, nbusy, elat - 1);
        check({name, "_quotient"}, quotient, eq);
        check({name, "_remainder"}, remainder, er);
        check({name, "_dbz"}, div_by_zero, edbz);
        $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0b latency=%0d", name, dd, dv,
                 quotient, remainder, div_by_zero, lat);
    endtask

    initial begin
        int ndone;
        int prev;
        bit ok;

        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        reset = 1'b1;

        run_op("200_7", 8'hC8, 4'h7, 8'h1C, 4'h4, 1'b0, 9);
        run_op("255_1", 8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 9);
        run_op("255_15", 8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 9);
        run_op("5_9", 8'h05, 4'h9, 8'h00, 4'h5, 1'b0, 9);
        run_op("0_3", 8'h00, 4'h3, 8'h00, 4'h0, 1'b0, 9);
        run_op("div0", 8'h42, 4'h0, 8'hFF, 4'h0, 1'b1, 1);
        run_op("9_3", 8'h09, 4'h3, 8'h03, 4'h0, 1'b0, 9);

        // A second start mid-RUN must be ignored.
        @(negedge CLK);
        dividend = 8'hC8; divisor = 4'h7; start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge CLK);
            start = 1'b0;
            if (k == 3) begin dividend = 8'h55; divisor = 4'h2; start = 1'b1; end
            if (done) begin
                ndone++;
                check("busy_start_quotient", quotient, 8'h1C);
                check("busy_start_remainder", remainder, 4'h4);
            end
        end
        check("busy_start_done_count", ndone, 1);
        $display("op start_while_busy: done pulses=%0d", ndone);

        // Reset in the middle of a divide.
        @(negedge CLK);
        dividend = 8'hC8; divisor = 4'h7; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        reset = 1'b0;
        @(negedge CLK);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_quotient", quotient, 0);
        check("midreset_remainder", remainder, 0);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge CLK);
            if (done) ndone++;
        end
        check("midreset_no_done", ndone, 0);
        $display("op reset_mid_run: done pulses afterwards=%0d", ndone);

        // Exhaustive back-to-back sweep with start held high.
        @(negedge CLK);
        sweep_on = 1'b1;
        for (int i = 0; i < 3840; i++) begin
            dividend = 8'(i / 15);
            divisor  = 4'(i % 15 + 1);
            start    = 1'b1;
            prev     = acc_cnt;
            ok       = 1'b0;
            for (int t = 0; t < 24; t++) begin
                @(negedge CLK);
                if (acc_cnt != prev) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                check("sweep_accept_timeout", 0, 1);
                break;
            end
        end
        start = 1'b0;
        repeat (12) @(negedge CLK);
        sweep_on = 1'b0;
        $display("op sweep: %0d requests accepted", acc_cnt);

        // Random traffic including zero divisors and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            start    = ($urandom_range(0, 3) == 0);
            dividend = 8'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            reset    = ($urandom_range(0, 79) != 0);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge CLK);
        $display("op random: total accepted requests=%0d", acc_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
